// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, MTHI/MTLO writes and MF stall.
// Optional MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;
  logic             dz_q, dz_d, done_q, done_d, div0_q, div0_d;

  logic             sgn, is_div, b_zero, legal, accept;
  logic             a_neg, b_neg;
  logic [W2-1:0]    a_ext, b_ext, prod, res;
  logic [WIDTH-1:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  // Signedness is op[0]==0 for every op in both the base and accumulate sets.
  assign sgn    = ~op[0];
  assign is_div = ~op[2] & op[1];
  assign b_zero = (b == '0);

  assign a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = a_ext * b_ext;

  // Sign-magnitude divide; most-negative / -1 wraps back to a with remainder 0.
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign b_div = b_zero ? WIDTH'(1) : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

`ifdef MULDIV_MADD_EN
  assign legal = 1'b1;
`else
  assign legal = ~op[2];
`endif

  assign accept = (state_q == IDLE) & start & legal;

  always_comb begin
    res = prod;
`ifdef MULDIV_MADD_EN
    // Base is the pre-edge {HI,LO}, so a same-cycle MTHI/MTLO does not leak in.
    if (op[2]) res = op[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
    if (is_div) res = {rem, quot};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    dz_d    = dz_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      if (accept) begin
        shi_d   = res[W2-1:WIDTH];
        slo_d   = res[WIDTH-1:0];
        dz_d    = is_div & b_zero;
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        div0_d  = 1'b0;
        state_d = RUN;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        div0_d  = dz_q;
        if (!dz_q) begin
          hi_d = shi_q;
          lo_d = slo_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = mf_req & (busy | accept);
  assign done  = done_q;
  assign div0  = div0_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
